// File: rtl/aes_pkg.sv
// Shared AES definitions used by the multi-channel selector buffer/checker:
// sparse selector encodings, selector width helper and checker FSM states.
package aes_pkg;

  // Eight 6-bit codes with pairwise Hamming distance >= 3 (a coset of a
  // shortened [6,3,3] code, offset so that neither all-zero nor all-one is used).
  localparam logic [7:0][5:0] SelEncTable = {
    6'b101110, 6'b100101, 6'b111011, 6'b110000,
    6'b001000, 6'b000011, 6'b011101, 6'b010110
  };

  localparam logic [5:0] MUX2_SEL_0 = SelEncTable[0];
  localparam logic [5:0] MUX2_SEL_1 = SelEncTable[1];
  localparam logic [5:0] MUX3_SEL_2 = SelEncTable[2];
  localparam logic [5:0] MUX4_SEL_3 = SelEncTable[3];
  localparam logic [5:0] MUX6_SEL_4 = SelEncTable[4];
  localparam logic [5:0] MUX6_SEL_5 = SelEncTable[5];

  function automatic bit SelNumOk(input int num);
    return (num == 2) || (num == 3) || (num == 4) || (num == 6) || (num == 8);
  endfunction

  // All supported mux sizes share the full-width sparse code.
  function automatic int SelWidth(input int num);
    return SelNumOk(num) ? 6 : 0;
  endfunction

  typedef enum logic [5:0] {
    SEL_CHK_IDLE   = 6'b001110,
    SEL_CHK_ALERT  = 6'b110101,
    SEL_CHK_LOCKED = 6'b100011
  } sel_chk_fsm_e;

endpackage

// File: rtl/aes_sel_chk_ch.sv
// One selector channel: per-bit buffer followed by a combinational check
// against the first Num sparse encodings.
module aes_sel_chk_ch
  import aes_pkg::*;
#(
  parameter int Num   = 4,
  parameter int Width = 6
) (
  input  logic [Width-1:0] sel_i,
  input  logic             vld_i,
  output logic [Width-1:0] sel_o,
  output logic             err_o
);

  localparam bit CfgOk = SelNumOk(Num) && (Width == SelWidth(Num));

  for (genvar b = 0; b < Width; b++) begin : g_buf
    prim_buf #(.Width(1)) u_buf (
      .in_i (sel_i[b]),
      .out_o(sel_o[b])
    );
  end

  if (CfgOk) begin : g_chk
    logic match;

    // The buffered value is checked so a fault between buffer and mux is seen.
    always_comb begin
      match = 1'b0;
      for (int i = 0; i < Num; i++) begin
        if (sel_o == SelEncTable[i][Width-1:0]) match = 1'b1;
      end
    end

    assign err_o = vld_i & ~match;
  end else begin : g_bad_cfg
    $error("aes_sel_chk_ch: unsupported Num or Width != SelWidth(Num)");
    assign err_o = vld_i;
  end

endmodule

// File: rtl/prim_buf.sv
// Buffer primitive; technology libraries replace this with a size-only cell.
module prim_buf #(
  parameter int Width = 1
) (
  input  logic [Width-1:0] in_i,
  output logic [Width-1:0] out_o
);

  assign out_o = in_i;

endmodule

// File: rtl/aes_sel_buf_chk_multi.sv
// Multi-channel sparse selector buffer/checker with sticky status, saturating
// error counter and fatal alert handshake. AES_SEL_CHK_CAPTURE_EN builds first-error capture.
module aes_sel_buf_chk_multi
  import aes_pkg::*;
#(
  parameter int NumCh    = 4,
  parameter int Num      = 4,
  parameter int Width    = 6,
  parameter int CntWidth = 8,
  localparam int CapW    = (NumCh > 1) ? $clog2(NumCh) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumCh*Width-1:0] sel_i,
  input  logic [NumCh-1:0]       vld_i,
  output logic [NumCh*Width-1:0] sel_o,
  output logic [NumCh-1:0]       err_comb_o,
  output logic [NumCh-1:0]       err_sticky_o,
  output logic [CntWidth-1:0]    err_cnt_o,
  output logic                   alert_req_o,
  input  logic                   alert_ack_i,
  output logic [CapW-1:0]        cap_ch_o,
  output logic [Width-1:0]       cap_sel_o,
  output logic                   cap_vld_o
);

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + CntWidth'(1);
  endfunction

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    aes_sel_chk_ch #(
      .Num  (Num),
      .Width(Width)
    ) u_ch (
      .sel_i(sel_i[c*Width +: Width]),
      .vld_i(vld_i[c]),
      .sel_o(sel_o[c*Width +: Width]),
      .err_o(err_comb_o[c])
    );
  end

  logic any_err;
  assign any_err = |err_comb_o;

  logic [NumCh-1:0]    err_sticky_q;
  logic [CntWidth-1:0] err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_sticky_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      err_sticky_q <= err_sticky_q | err_comb_o;
      if (any_err) err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign err_sticky_o = err_sticky_q;
  assign err_cnt_o    = err_cnt_q;

  sel_chk_fsm_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= SEL_CHK_IDLE;
    else         state_q <= state_d;
  end

  // LOCKED is terminal until reset; any corrupted state falls back to ALERT.
  always_comb begin
    state_d     = state_q;
    alert_req_o = 1'b0;
    unique case (state_q)
      SEL_CHK_IDLE: begin
        if (any_err) state_d = SEL_CHK_ALERT;
      end
      SEL_CHK_ALERT: begin
        alert_req_o = 1'b1;
        if (alert_ack_i) state_d = SEL_CHK_LOCKED;
      end
      SEL_CHK_LOCKED: begin
        state_d = SEL_CHK_LOCKED;
      end
      default: begin
        alert_req_o = 1'b1;
        state_d     = SEL_CHK_ALERT;
      end
    endcase
  end

`ifdef AES_SEL_CHK_CAPTURE_EN
  logic [CapW-1:0]  first_ch;
  logic [Width-1:0] first_sel;
  logic [CapW-1:0]  cap_ch_q;
  logic [Width-1:0] cap_sel_q;
  logic             cap_vld_q;

  // Descending scan so the lowest erroring index wins.
  always_comb begin
    first_ch  = '0;
    first_sel = '0;
    for (int c = NumCh - 1; c >= 0; c--) begin
      if (err_comb_o[c]) begin
        first_ch  = CapW'(c);
        first_sel = sel_o[c*Width +: Width];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cap_ch_q  <= '0;
      cap_sel_q <= '0;
      cap_vld_q <= 1'b0;
    end else if (any_err && !cap_vld_q) begin
      cap_ch_q  <= first_ch;
      cap_sel_q <= first_sel;
      cap_vld_q <= 1'b1;
    end
  end

  assign cap_ch_o  = cap_ch_q;
  assign cap_sel_o = cap_sel_q;
  assign cap_vld_o = cap_vld_q;
`else
  assign cap_ch_o  = '0;
  assign cap_sel_o = '0;
  assign cap_vld_o = 1'b0;
`endif

endmodule
